// File: rtl/mips_core_pkg.sv
// Shared types and constants for the core's branch-prediction path.
// Contents: branch direction encoding, 2-bit counter type and its named states,
// the global-history width shared by the pipe interfaces, and a
// saturating-step helper.
package mips_core_pkg;

  // Global-history width carried down the pipe with every branch.
  localparam int unsigned G_HISTORY_BITS = 8;

  typedef enum logic {
    NOT_TAKEN = 1'b0,
    TAKEN     = 1'b1
  } branch_outcome_e;

  typedef logic [1:0] counter_t;

  localparam counter_t WEAK_NT = 2'b01;
  localparam counter_t WEAK_T  = 2'b10;

  // One step of a 2-bit saturating counter toward the given direction.
  function automatic counter_t sat_step(counter_t cur, logic dir);
    counter_t nxt;
    nxt = cur;
    if (dir == TAKEN) begin
      if (cur != 2'b11) nxt = cur + 2'b01;
    end else begin
      if (cur != 2'b00) nxt = cur - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Array of 2-bit saturating counters held in flops.
// Ports:
//   clk, rst          clock and asynchronous active-high reset (all entries -> RESET_VAL)
//   rd_idx, rd_ctr_c  combinational read port (returns the pre-update value on a same-cycle train)
//   train_en          apply one saturating step this cycle
//   train_idx         entry to step
//   train_dir         step direction (1 = up, 0 = down)
module sat_counter_table
  import mips_core_pkg::counter_t;
  import mips_core_pkg::sat_step;
#(
  parameter int unsigned INDEX_BITS = 8,
  parameter counter_t    RESET_VAL  = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output counter_t              rd_ctr_c,
  input  logic                  train_en,
  input  logic [INDEX_BITS-1:0] train_idx,
  input  logic                  train_dir
);

  localparam int unsigned ENTRIES = 1 << INDEX_BITS;

  counter_t ctr [ENTRIES];

  assign rd_ctr_c = ctr[rd_idx];

  // Counter storage; one entry stepped per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        ctr[i] <= RESET_VAL;
      end
    end else if (train_en) begin
      ctr[train_idx] <= sat_step(ctr[train_idx], train_dir);
    end
  end

endmodule

// File: rtl/branch_predictor_tournament.sv
// Tournament direction predictor: gshare + PC-indexed bimodal + chooser.
// Front side: zero-latency lookup of i_req_pc against the speculative GHR,
//   returning final/gshare/bimodal directions and the GHR used (o_ghistory).
// Back side: i_res_* trains all three tables and repairs the GHR on a
//   mispredict; o_mispredict is a registered one-cycle pulse per mispredict.
// Ports: clk, rst (async, active-high); i_req_valid/i_req_pc/i_stall;
//   o_prediction, o_prediction_gshare, o_prediction_2bit, o_ghistory;
//   i_res_valid, i_res_pc, i_res_ghistory, i_res_prediction,
//   i_res_prediction_gshare, i_res_prediction_2bit, i_res_outcome; o_mispredict.
module branch_predictor_tournament
  import mips_core_pkg::counter_t;
  import mips_core_pkg::WEAK_NT;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned G_HISTORY_BITS = mips_core_pkg::G_HISTORY_BITS,
  parameter int unsigned INDEX_BITS     = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req_valid,
  input  logic [ADDR_WIDTH-1:0]     i_req_pc,
  input  logic                      i_stall,
  output logic                      o_prediction,
  output logic                      o_prediction_gshare,
  output logic                      o_prediction_2bit,
  output logic [G_HISTORY_BITS-1:0] o_ghistory,
  input  logic                      i_res_valid,
  input  logic [ADDR_WIDTH-1:0]     i_res_pc,
  input  logic [G_HISTORY_BITS-1:0] i_res_ghistory,
  input  logic                      i_res_prediction,
  input  logic                      i_res_prediction_gshare,
  input  logic                      i_res_prediction_2bit,
  input  logic                      i_res_outcome,
  output logic                      o_mispredict
);

  logic [G_HISTORY_BITS-1:0] ghr;

  logic [INDEX_BITS-1:0] req_bim_idx;
  logic [INDEX_BITS-1:0] req_gsh_idx;
  logic [INDEX_BITS-1:0] res_bim_idx;
  logic [INDEX_BITS-1:0] res_gsh_idx;

  counter_t bim_ctr;
  counter_t gsh_ctr;
  counter_t cho_ctr;

  logic gshare_correct;
  logic components_disagree;
  logic mispredict_c;

  // Only the word-aligned index bits select an entry; the rest alias.
  assign req_bim_idx = i_req_pc[INDEX_BITS+1:2];
  assign req_gsh_idx = req_bim_idx ^ INDEX_BITS'(ghr);
  assign res_bim_idx = i_res_pc[INDEX_BITS+1:2];
  assign res_gsh_idx = res_bim_idx ^ INDEX_BITS'(i_res_ghistory);

  assign gshare_correct      = (i_res_prediction_gshare == i_res_outcome);
  assign components_disagree = (i_res_prediction_gshare != i_res_prediction_2bit);
  assign mispredict_c        = i_res_valid && (i_res_prediction != i_res_outcome);

  sat_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .RESET_VAL  (WEAK_NT)
  ) u_bimodal (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (req_bim_idx),
    .rd_ctr_c  (bim_ctr),
    .train_en  (i_res_valid),
    .train_idx (res_bim_idx),
    .train_dir (i_res_outcome)
  );

  sat_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .RESET_VAL  (WEAK_NT)
  ) u_gshare (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (req_gsh_idx),
    .rd_ctr_c  (gsh_ctr),
    .train_en  (i_res_valid),
    .train_idx (res_gsh_idx),
    .train_dir (i_res_outcome)
  );

  // Chooser learns only when the components disagree; up favours gshare.
  sat_counter_table #(
    .INDEX_BITS (INDEX_BITS),
    .RESET_VAL  (WEAK_NT)
  ) u_chooser (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (req_bim_idx),
    .rd_ctr_c  (cho_ctr),
    .train_en  (i_res_valid && components_disagree),
    .train_idx (res_bim_idx),
    .train_dir (gshare_correct)
  );

  // Counter MSB is the direction / selection.
  assign o_prediction_gshare = gsh_ctr[1];
  assign o_prediction_2bit   = bim_ctr[1];
  assign o_prediction        = cho_ctr[1] ? gsh_ctr[1] : bim_ctr[1];
  assign o_ghistory          = ghr;

  // Speculative history; a mispredict repair wins over a wrong-path shift.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr          <= '0;
      o_mispredict <= 1'b0;
    end else begin
      o_mispredict <= mispredict_c;
      if (mispredict_c) begin
        ghr <= {i_res_ghistory[G_HISTORY_BITS-2:0], i_res_outcome};
      end else if (i_req_valid && !i_stall) begin
        ghr <= {ghr[G_HISTORY_BITS-2:0], o_prediction};
      end
    end
  end

  logic unused_pc_bits;
  assign unused_pc_bits = ^{i_req_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_req_pc[1:0],
                            i_res_pc[ADDR_WIDTH-1:INDEX_BITS+2], i_res_pc[1:0]};

endmodule

// File: doc/branch_predictor_tournament.md
Name: branch_predictor_tournament

Overview:
Tournament direction predictor feeding the decode/hazard branch-prediction path. It combines a gshare table, a PC-indexed 2-bit bimodal table and a 2-bit chooser.
- Front side: looks up a direction for each decoded conditional branch and returns the final prediction, both component predictions and the global-history snapshot used. These travel down the pipe with the branch.
- Back side: consumes resolved-branch results from the ALU stage to train all three tables and repair the speculative global history.

Parameters:
ADDR_WIDTH, 32, PC width
G_HISTORY_BITS, 8, global history register width; must be <= INDEX_BITS
INDEX_BITS, 8, log2 of entries per table (gshare, bimodal, chooser)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
i_req_valid  in  1  decoded instruction is a conditional branch (valid && !is_jump)
i_req_pc  in  ADDR_WIDTH  PC of that branch
i_stall  in  1  decode stage stalled; lookup is repeated next cycle
o_prediction  out  1  final direction (1 = TAKEN)
o_prediction_gshare  out  1  gshare component direction
o_prediction_2bit  out  1  bimodal component direction
o_ghistory  out  G_HISTORY_BITS  GHR value used for this lookup
i_res_valid  in  1  branch resolved this cycle
i_res_pc  in  ADDR_WIDTH  PC of the resolved branch
i_res_ghistory  in  G_HISTORY_BITS  history snapshot carried with the branch
i_res_prediction  in  1  final prediction that was made
i_res_prediction_gshare  in  1  gshare prediction that was made
i_res_prediction_2bit  in  1  bimodal prediction that was made
i_res_outcome  in  1  actual direction
o_mispredict  out  1  registered, one-cycle pulse: last resolution mispredicted (debug/stats)

Behaviour:
- Tables:
  - Three arrays of 2^INDEX_BITS 2-bit saturating counters in flops.
  - Counter >= 2 means TAKEN for gshare/bimodal; chooser >= 2 selects gshare.
- Indexing:
  - bimodal_idx = pc[INDEX_BITS+1:2]
  - gshare_idx = pc[INDEX_BITS+1:2] XOR zero-extended history
  - chooser_idx = bimodal_idx
- Lookup:
  - Combinational, zero-latency read.
  - o_* reflect the current i_req_pc and the current GHR every cycle, regardless of i_req_valid.
- Speculative GHR:
  - On rising clk with i_req_valid && !i_stall and no mispredicting resolution: GHR <= {GHR[G_HISTORY_BITS-2:0], o_prediction}.
- Resolution (i_res_valid):
  - Bimodal counter[res bimodal idx] moves toward outcome, saturating at 0/3.
  - Gshare counter[res_pc-derived idx XOR i_res_ghistory] moves toward outcome, saturating.
  - Chooser is updated only if i_res_prediction_gshare != i_res_prediction_2bit: increment if gshare was correct, else decrement; saturating.
  - If i_res_prediction != i_res_outcome: GHR <= {i_res_ghistory[G_HISTORY_BITS-2:0], i_res_outcome}.
- Simultaneous events:
  - A mispredicting resolution overrides any same-cycle speculative shift, because the lookup is on the wrong path.
  - A correct resolution does not touch the GHR, so a same-cycle lookup shift proceeds.
- Read-during-write: a same-cycle lookup of an entry being trained sees the old value; the new value is visible the next cycle.
- o_mispredict <= i_res_valid && (i_res_prediction != i_res_outcome).
- Reset (asynchronous, any time, including mid-stream):
  - All gshare/bimodal counters = 2'b01 (weakly not-taken).
  - All chooser counters = 2'b01 (weakly bimodal).
  - GHR = 0; o_mispredict = 0.
  - Combinational outputs after reset: o_prediction = 0, o_prediction_gshare = 0, o_prediction_2bit = 0, o_ghistory = 0.
- High PC bits above INDEX_BITS+1 and pc[1:0] are ignored; aliasing is permitted.

Decomposition:
- Package mips_core_pkg holds:
  - BranchOutcome encoding (NOT_TAKEN = 0, TAKEN = 1).
  - Counter typedef (2-bit) and constants WEAK_NT = 2'b01, WEAK_T = 2'b10.
  - G_HISTORY_BITS stays the shared define used by the pass-through interfaces.
- Sub-module sat_counter_table: parameterised 2-bit saturating-counter array with combinational read port, one train port (idx, dir) and async reset value. Instantiated three times; the chooser uses the gshare-correct flag as its dir.

Test Plan:
- Reset then lookup PC 0x00400010 -> o_prediction = 0, gshare = 0, 2bit = 0, o_ghistory = 0x00.
- Resolve PC 0x00400010 taken twice with history 0x00, predictions all 0 -> bimodal entry 4 reaches 3. GHR restored to 0x01 after the first resolution, 0x01 after the second. o_mispredict pulses each cycle.
- Three lookups with i_req_valid = 1 and prediction TAKEN, one with i_stall = 1 -> GHR shifts exactly 3 times (0x01 -> 0x03 -> 0x07 -> 0x0F). No shift on the stalled cycle.
- Same cycle: lookup valid and mispredicted resolution with i_res_ghistory = 0xA5, outcome = 0 -> GHR = 0x4A next cycle; the speculative shift is discarded.
- Alternating T/NT branch at one PC, 40 resolutions with correct history -> gshare becomes correct, chooser saturates to 3, and the final prediction matches the outcome for the last 10.
- Assert rst mid-training with counters at 3 -> all outputs return to reset values immediately, without waiting for clk.
